// File: rtl/alu_seq_pkg.sv
// Shared opcode and FSM encodings for the sequential ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_seq_pkg;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_CMP = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative shift-add unsigned multiplier, one partial product per cycle.
// Latency: W cycles after start; done flags the final iteration cycle.
// Backpressure: none; the caller sequences start and consumes product on done.
module alu_seq_mul #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = $clog2(W) + 1;

  logic           busy;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] mcand;
  logic [2*W-1:0] prod;
  logic [W-1:0]   mplier;
  logic [2*W-1:0] addend;

  // Next partial product; on the last iteration this is the final result,
  // so the caller can register it in the same cycle done is high.
  always_comb begin
    addend  = mplier[0] ? mcand : '0;
    product = prod + addend;
    done    = busy && (cnt == CW'(W - 1));
  end

  // Load operands on start, then one shift-add step per cycle for W cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= {{W{1'b0}}, a};
      prod   <= '0;
      mplier <= b;
    end else if (busy) begin
      prod   <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: add/sub (and compare with ALU_SEQ_CMP_EN) in one cycle, mul iterative.
// Latency: result valid 1 cycle after acceptance for add/sub/cmp/invalid, W+1 cycles for mul.
// Backpressure: one op in flight; in_ready low until the result is taken via out_valid/out_ready.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     op,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   z,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] y,
  output logic           err
);

  state_t         state;
  logic           mul_start;
  logic           mul_done;
  logic [2*W-1:0] mul_product;
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [2*W-1:0] fast_y;
  logic           fast_err;

  // Single-cycle results; bit W of the (W+1)-bit difference is the borrow.
  always_comb begin
    sum      = {1'b0, x} + {1'b0, z};
    diff     = {1'b0, x} - {1'b0, z};
    fast_y   = '0;
    fast_err = 1'b0;
    case (op)
      OP_ADD: fast_y = {{(W-1){1'b0}}, sum};
      OP_SUB: fast_y = {{(W-1){1'b0}}, diff};
`ifdef ALU_SEQ_CMP_EN
      OP_CMP: fast_y = {{(2*W-3){1'b0}}, (x > z), (x == z), (x < z)};
`endif
      default: fast_err = 1'b1;
    endcase
  end

  assign mul_start = (state == S_IDLE) && in_valid && (op == OP_MUL);

  alu_seq_mul #(.W(W)) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (x),
    .b       (z),
    .done    (mul_done),
    .product (mul_product)
  );

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      y         <= '0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (op == OP_MUL) begin
              state <= S_MUL;
            end else begin
              y         <= fast_y;
              err       <= fast_err;
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_MUL: begin
          if (mul_done) begin
            y         <= mul_product;
            err       <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at W=8.
// Latency: checks acceptance-to-result timing for single-cycle ops and mul.
// Backpressure: exercises out_ready stalls and reset during a multiply.
module tb_alu_seq;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     op;
  logic [W-1:0]   x;
  logic [W-1:0]   z;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] y;
  logic           err;

  int n_checks = 0;
  int n_errors = 0;
  int hs_cnt   = 0;

  alu_seq #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x         (x),
    .z         (z),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready) hs_cnt <= hs_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single acceptance edge, then drop in_valid.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    chk("in_ready_before_issue", 32'(in_ready), 32'd1);
    op       = o;
    x        = a;
    z        = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Wait for out_valid after acceptance; returns the number of extra edges.
  task automatic wait_result(output int k);
    k = 0;
    while (!out_valid && k < 40) begin
      tick();
      k++;
    end
  endtask

  // Take the result with a one-cycle out_ready pulse.
  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("out_valid_after_take", 32'(out_valid), 32'd0);
    chk("in_ready_after_take", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int k;
    int hs0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = 2'd0;
    x         = '0;
    z         = '0;

    // Reset for 3 cycles.
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // add 200+100, out_ready held high.
    out_ready = 1'b1;
    issue(2'd0, 8'd200, 8'd100);
    chk("add_out_valid_n1", 32'(out_valid), 32'd1);
    chk("add_in_ready_n1", 32'(in_ready), 32'd0);
    chk("add_y", 32'(y), 32'h012C);
    chk("add_err", 32'(err), 32'd0);
    tick();
    chk("add_pulse_end", 32'(out_valid), 32'd0);
    chk("add_in_ready_n2", 32'(in_ready), 32'd1);
    out_ready = 1'b0;

    // add carry boundary 255+255.
    issue(2'd0, 8'd255, 8'd255);
    chk("add_max_y", 32'(y), 32'h01FE);
    take();

    // sub 5-7 with 4 stalled cycles.
    hs0 = hs_cnt;
    issue(2'd1, 8'd5, 8'd7);
    for (int i = 0; i < 4; i++) begin
      chk("sub_hold_valid", 32'(out_valid), 32'd1);
      chk("sub_hold_y", 32'(y), 32'h01FE);
      chk("sub_hold_err", 32'(err), 32'd0);
      if (i < 3) tick();
    end
    take();
    repeat (2) tick();
    chk("sub_handshakes", 32'(hs_cnt - hs0), 32'd1);

    // sub without borrow.
    issue(2'd1, 8'd7, 8'd5);
    chk("sub_nb_y", 32'(y), 32'h0002);
    take();

    // mul 200*255: result W edges after acceptance.
    issue(2'd2, 8'd200, 8'd255);
    chk("mul_in_ready_busy", 32'(in_ready), 32'd0);
    chk("mul_out_valid_n1", 32'(out_valid), 32'd0);
    wait_result(k);
    chk("mul_latency", 32'(k), 32'd8);
    chk("mul_y", 32'(y), 32'hC738);
    chk("mul_err", 32'(err), 32'd0);
    take();

    // mul 0*255.
    issue(2'd2, 8'd0, 8'hFF);
    wait_result(k);
    chk("mul_zero_latency", 32'(k), 32'd8);
    chk("mul_zero_y", 32'(y), 32'd0);
    take();

    // mul 255*255.
    issue(2'd2, 8'hFF, 8'hFF);
    wait_result(k);
    chk("mul_max_y", 32'(y), 32'hFE01);
    take();

    // op 3: compare or invalid depending on build.
    issue(2'd3, 8'd9, 8'd9);
    chk("op3_valid_n1", 32'(out_valid), 32'd1);
`ifdef ALU_SEQ_CMP_EN
    chk("cmp_eq_y", 32'(y), 32'h0002);
    chk("cmp_eq_err", 32'(err), 32'd0);
    take();
    issue(2'd3, 8'd10, 8'd3);
    chk("cmp_gt_y", 32'(y), 32'h0004);
    take();
`else
    chk("inv_y", 32'(y), 32'd0);
    chk("inv_err", 32'(err), 32'd1);
    take();
    issue(2'd0, 8'd3, 8'd4);
    chk("err_clears_y", 32'(y), 32'h0007);
    chk("err_clears_err", 32'(err), 32'd0);
    take();
`endif

    // Reset 4 cycles into a mul aborts it.
    issue(2'd2, 8'd200, 8'd255);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_y", 32'(y), 32'd0);
    k = 0;
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (out_valid) k++;
    end
    chk("abort_no_result", 32'(k), 32'd0);
    issue(2'd0, 8'd1, 8'd1);
    chk("post_abort_valid", 32'(out_valid), 32'd1);
    chk("post_abort_y", 32'(y), 32'h0002);
    take();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1);
  end

endmodule
